// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: EX-stage operand forwarding selects and load-use stall control
// for a 5-stage MIPS pipeline. Tracks destination registers in EX/MEM/WB.
// Optional macro FWD_PERF_EN adds stall_cnt/fwd_cnt performance counters.
module fwd_hazard_ctrl #(
   parameter int unsigned REG_W        = 5,
   parameter int unsigned STALL_CYCLES = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             id_wr_en,
   input  logic [REG_W-1:0] id_wr_reg,
   input  logic             id_is_load,
   input  logic             flush,
   output logic             stall,
   output logic [1:0]       forward_a,
   output logic [1:0]       forward_b
`ifdef FWD_PERF_EN
   ,
   output logic [31:0]      stall_cnt,
   output logic [31:0]      fwd_cnt
`endif
);

   localparam int unsigned CNT_W = 2;

   typedef enum logic {ST_RUN, ST_WAIT} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               ex_valid_q, ex_valid_d;
   logic [REG_W-1:0]   ex_rs_q, ex_rs_d;
   logic [REG_W-1:0]   ex_rt_q, ex_rt_d;
   logic               ex_use_rs_q, ex_use_rs_d;
   logic               ex_use_rt_q, ex_use_rt_d;
   logic               ex_wr_en_q, ex_wr_en_d;
   logic [REG_W-1:0]   ex_wr_reg_q, ex_wr_reg_d;
   logic               ex_is_load_q, ex_is_load_d;

   logic               mem_wr_en_q, mem_wr_en_d;
   logic [REG_W-1:0]   mem_wr_reg_q, mem_wr_reg_d;
   logic               mem_is_load_q, mem_is_load_d;

   logic               wb_wr_en_q, wb_wr_en_d;
   logic [REG_W-1:0]   wb_wr_reg_q, wb_wr_reg_d;

   logic               hazard_c;

   // Load in EX whose destination is read by the instruction in ID
   always_comb begin
      hazard_c = id_valid && ex_valid_q && ex_is_load_q && ex_wr_en_q &&
                 (ex_wr_reg_q != '0) &&
                 ((id_use_rs && (id_rs == ex_wr_reg_q)) ||
                  (id_use_rt && (id_rt == ex_wr_reg_q)));
   end

   // Stall FSM: combinational stall in RUN, held high for the remaining WAIT cycles
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stall   = 1'b0;
      case (state_q)
         ST_RUN: begin
            stall = hazard_c;
            if (hazard_c && (STALL_CYCLES > 1)) begin
               state_d = ST_WAIT;
               cnt_d   = CNT_W'(STALL_CYCLES - 1);
            end
         end
         ST_WAIT: begin
            stall = 1'b1;
            if (cnt_q <= CNT_W'(1)) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_RUN;
            cnt_d   = '0;
         end
      endcase
   end

   // Stage records: EX takes ID or a bubble, MEM and WB always advance
   always_comb begin
      ex_valid_d   = 1'b0;
      ex_rs_d      = id_rs;
      ex_rt_d      = id_rt;
      ex_use_rs_d  = 1'b0;
      ex_use_rt_d  = 1'b0;
      ex_wr_en_d   = 1'b0;
      ex_wr_reg_d  = id_wr_reg;
      ex_is_load_d = 1'b0;
      if (id_valid && !stall && !flush) begin
         ex_valid_d   = 1'b1;
         ex_use_rs_d  = id_use_rs;
         ex_use_rt_d  = id_use_rt;
         ex_wr_en_d   = id_wr_en;
         ex_is_load_d = id_is_load;
      end
      mem_wr_en_d   = ex_wr_en_q;
      mem_wr_reg_d  = ex_wr_reg_q;
      mem_is_load_d = ex_is_load_q;
      wb_wr_en_d    = mem_wr_en_q;
      wb_wr_reg_d   = mem_wr_reg_q;
   end

   // Forward selects: MEM ALUResult (younger, never a load address) beats WB WData
   always_comb begin
      forward_a = 2'b00;
      forward_b = 2'b00;
      if (ex_use_rs_q && mem_wr_en_q && !mem_is_load_q && (mem_wr_reg_q != '0) &&
          (mem_wr_reg_q == ex_rs_q))
         forward_a = 2'b10;
      else if (ex_use_rs_q && wb_wr_en_q && (wb_wr_reg_q != '0) && (wb_wr_reg_q == ex_rs_q))
         forward_a = 2'b01;
      if (ex_use_rt_q && mem_wr_en_q && !mem_is_load_q && (mem_wr_reg_q != '0) &&
          (mem_wr_reg_q == ex_rt_q))
         forward_b = 2'b10;
      else if (ex_use_rt_q && wb_wr_en_q && (wb_wr_reg_q != '0) && (wb_wr_reg_q == ex_rt_q))
         forward_b = 2'b01;
   end

   // State and stage-record registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_RUN;
         cnt_q         <= '0;
         ex_valid_q    <= 1'b0;
         ex_rs_q       <= '0;
         ex_rt_q       <= '0;
         ex_use_rs_q   <= 1'b0;
         ex_use_rt_q   <= 1'b0;
         ex_wr_en_q    <= 1'b0;
         ex_wr_reg_q   <= '0;
         ex_is_load_q  <= 1'b0;
         mem_wr_en_q   <= 1'b0;
         mem_wr_reg_q  <= '0;
         mem_is_load_q <= 1'b0;
         wb_wr_en_q    <= 1'b0;
         wb_wr_reg_q   <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         ex_valid_q    <= ex_valid_d;
         ex_rs_q       <= ex_rs_d;
         ex_rt_q       <= ex_rt_d;
         ex_use_rs_q   <= ex_use_rs_d;
         ex_use_rt_q   <= ex_use_rt_d;
         ex_wr_en_q    <= ex_wr_en_d;
         ex_wr_reg_q   <= ex_wr_reg_d;
         ex_is_load_q  <= ex_is_load_d;
         mem_wr_en_q   <= mem_wr_en_d;
         mem_wr_reg_q  <= mem_wr_reg_d;
         mem_is_load_q <= mem_is_load_d;
         wb_wr_en_q    <= wb_wr_en_d;
         wb_wr_reg_q   <= wb_wr_reg_d;
      end
   end

`ifdef FWD_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] fwd_cnt_q, fwd_cnt_d;

   // Performance counters: one count per cycle, wrapping at 2^32
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      fwd_cnt_d   = fwd_cnt_q;
      if (stall)
         stall_cnt_d = stall_cnt_q + 32'd1;
      if ((forward_a != 2'b00) || (forward_b != 2'b00))
         fwd_cnt_d = fwd_cnt_q + 32'd1;
   end

   // Performance counter registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt_q <= '0;
         fwd_cnt_q   <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         fwd_cnt_q   <= fwd_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: directed scenarios for fwd_hazard_ctrl with STALL_CYCLES=1 and =3.
`timescale 1ns/1ps
module tb_fwd_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst1_n = 1'b1;
   logic       rst3_n = 1'b1;
   logic       id_valid = 1'b0;
   logic [4:0] id_rs = '0;
   logic [4:0] id_rt = '0;
   logic       id_use_rs = 1'b0;
   logic       id_use_rt = 1'b0;
   logic       id_wr_en = 1'b0;
   logic [4:0] id_wr_reg = '0;
   logic       id_is_load = 1'b0;
   logic       flush = 1'b0;

   logic       stall1, stall3;
   logic [1:0] fa1, fb1, fa3, fb3;
`ifdef FWD_PERF_EN
   logic [31:0] stall_cnt1, fwd_cnt1, stall_cnt3, fwd_cnt3;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   fwd_hazard_ctrl #(.REG_W(5), .STALL_CYCLES(1)) u_sc1 (
      .clk(clk), .reset_n(rst1_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en),
      .id_wr_reg(id_wr_reg), .id_is_load(id_is_load), .flush(flush),
      .stall(stall1), .forward_a(fa1), .forward_b(fb1)
`ifdef FWD_PERF_EN
      , .stall_cnt(stall_cnt1), .fwd_cnt(fwd_cnt1)
`endif
   );

   fwd_hazard_ctrl #(.REG_W(5), .STALL_CYCLES(3)) u_sc3 (
      .clk(clk), .reset_n(rst3_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en),
      .id_wr_reg(id_wr_reg), .id_is_load(id_is_load), .flush(flush),
      .stall(stall3), .forward_a(fa3), .forward_b(fb3)
`ifdef FWD_PERF_EN
      , .stall_cnt(stall_cnt3), .fwd_cnt(fwd_cnt3)
`endif
   );

   // Present an instruction in ID
   task automatic set_id(input int v, input int rs, input int rt, input int urs,
                         input int urt, input int we, input int wr, input int ld);
      id_valid   = (v != 0);
      id_rs      = 5'(rs);
      id_rt      = 5'(rt);
      id_use_rs  = (urs != 0);
      id_use_rt  = (urt != 0);
      id_wr_en   = (we != 0);
      id_wr_reg  = 5'(wr);
      id_is_load = (ld != 0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      flush = 1'b0;
      repeat (4) tick();
   endtask

   task automatic test_reset();
      set_id(1, 2, 2, 1, 1, 1, 4, 0);
      #1;
      rst1_n = 1'b0;
      rst3_n = 1'b0;
      #2;
      n_tests++; if (stall1 !== 1'b0) begin n_fail++; $display("FAIL reset_stall1: got %b want 0", stall1); end
      n_tests++; if ({fa1, fb1} !== 4'b0000) begin n_fail++; $display("FAIL reset_fwd1: got %b want 0000", {fa1, fb1}); end
      n_tests++; if (stall3 !== 1'b0) begin n_fail++; $display("FAIL reset_stall3: got %b want 0", stall3); end
      repeat (2) tick();
      rst1_n = 1'b1;
      rst3_n = 1'b1;
      #1;
      n_tests++; if ({stall1, fa1, fb1} !== 5'b00000) begin n_fail++; $display("FAIL reset_release1: got %b want 00000", {stall1, fa1, fb1}); end
      n_tests++; if ({stall3, fa3, fb3} !== 5'b00000) begin n_fail++; $display("FAIL reset_release3: got %b want 00000", {stall3, fa3, fb3}); end
   endtask

   task automatic test_mem_forward();
      drain();
      set_id(1, 1, 2, 1, 1, 1, 3, 0); tick();   // add $3,$1,$2
      set_id(1, 3, 5, 1, 1, 1, 4, 0); tick();   // sub $4,$3,$5
      n_tests++; if (fa1 !== 2'b10) begin n_fail++; $display("FAIL mem_fwd_a: got %b want 10", fa1); end
      n_tests++; if (fb1 !== 2'b00) begin n_fail++; $display("FAIL mem_fwd_b: got %b want 00", fb1); end
      n_tests++; if (stall1 !== 1'b0) begin n_fail++; $display("FAIL mem_fwd_stall: got %b want 0", stall1); end
   endtask

   task automatic test_wb_forward();
      drain();
      set_id(1, 1, 2, 1, 1, 1, 3, 0); tick();   // add $3
      set_id(0, 0, 0, 0, 0, 0, 0, 0); tick();   // nop
      set_id(1, 7, 3, 1, 1, 1, 6, 0); tick();   // or $6,$7,$3
      n_tests++; if (fb1 !== 2'b01) begin n_fail++; $display("FAIL wb_fwd_b: got %b want 01", fb1); end
      n_tests++; if (fa1 !== 2'b00) begin n_fail++; $display("FAIL wb_fwd_a: got %b want 00", fa1); end
   endtask

   task automatic test_priority();
      drain();
      set_id(1, 1, 2, 1, 1, 1, 3, 0); tick();   // add $3
      set_id(1, 3, 0, 1, 0, 1, 3, 0); tick();   // addi $3,$3,1
      n_tests++; if ({fa1, fb1} !== 4'b1000) begin n_fail++; $display("FAIL prio_addi: got %b want 1000", {fa1, fb1}); end
      set_id(1, 3, 3, 1, 1, 1, 8, 0); tick();   // and $8,$3,$3
      n_tests++; if ({fa1, fb1} !== 4'b1010) begin n_fail++; $display("FAIL prio_and: got %b want 1010", {fa1, fb1}); end
   endtask

   task automatic test_zero_reg();
      drain();
      set_id(1, 1, 0, 1, 0, 1, 0, 0); tick();   // ori $0,$1,5
      set_id(1, 0, 0, 1, 1, 1, 2, 0); tick();   // add $2,$0,$0
      n_tests++; if ({fa1, fb1} !== 4'b0000) begin n_fail++; $display("FAIL zero_mem: got %b want 0000", {fa1, fb1}); end
      set_id(1, 0, 0, 1, 1, 1, 5, 0); tick();   // add $5,$0,$0 with $0 writer in WB
      n_tests++; if ({fa1, fb1} !== 4'b0000) begin n_fail++; $display("FAIL zero_wb: got %b want 0000", {fa1, fb1}); end
   endtask

   task automatic test_load_use();
      drain();
      set_id(1, 1, 0, 1, 0, 1, 2, 1); tick();   // lw $2,0($1)
      set_id(1, 2, 2, 1, 1, 1, 4, 0); #1;       // add $4,$2,$2
      n_tests++; if (stall1 !== 1'b1) begin n_fail++; $display("FAIL lu_stall_on: got %b want 1", stall1); end
      tick();
      n_tests++; if (stall1 !== 1'b0) begin n_fail++; $display("FAIL lu_stall_off: got %b want 0", stall1); end
      n_tests++; if ({fa1, fb1} !== 4'b0000) begin n_fail++; $display("FAIL lu_bubble: got %b want 0000", {fa1, fb1}); end
      tick();
      n_tests++; if ({fa1, fb1} !== 4'b0101) begin n_fail++; $display("FAIL lu_wb_fwd: got %b want 0101", {fa1, fb1}); end
      n_tests++; if (stall1 !== 1'b0) begin n_fail++; $display("FAIL lu_after: got %b want 0", stall1); end
   endtask

   task automatic test_back_to_back();
      drain();
      set_id(1, 1, 0, 1, 0, 1, 2, 1); tick();   // lw $2,0($1)
      set_id(1, 2, 0, 1, 0, 1, 3, 1); #1;       // lw $3,0($2)
      n_tests++; if (stall1 !== 1'b1) begin n_fail++; $display("FAIL b2b_stall1: got %b want 1", stall1); end
      tick();
      n_tests++; if (stall1 !== 1'b0) begin n_fail++; $display("FAIL b2b_release1: got %b want 0", stall1); end
      tick();
      n_tests++; if (fa1 !== 2'b01) begin n_fail++; $display("FAIL b2b_lw_fwd: got %b want 01", fa1); end
      set_id(1, 3, 3, 1, 1, 1, 4, 0); #1;       // add $4,$3,$3
      n_tests++; if (stall1 !== 1'b1) begin n_fail++; $display("FAIL b2b_stall2: got %b want 1", stall1); end
      tick();
      n_tests++; if (stall1 !== 1'b0) begin n_fail++; $display("FAIL b2b_release2: got %b want 0", stall1); end
      tick();
      n_tests++; if ({fa1, fb1} !== 4'b0101) begin n_fail++; $display("FAIL b2b_add_fwd: got %b want 0101", {fa1, fb1}); end
   endtask

   task automatic test_flush();
      drain();
      set_id(1, 1, 2, 1, 1, 1, 3, 0); flush = 1'b1; tick();   // add $3 flushed
      flush = 1'b0;
      set_id(1, 3, 5, 1, 1, 1, 4, 0); tick();                  // sub $4,$3,$5
      n_tests++; if ({fa1, fb1} !== 4'b0000) begin n_fail++; $display("FAIL flush_bubble: got %b want 0000", {fa1, fb1}); end
      drain();
      set_id(1, 1, 0, 1, 0, 1, 2, 1); tick();                  // lw $2
      set_id(1, 2, 2, 1, 1, 1, 4, 0); flush = 1'b1; #1;        // add $4,$2,$2 with flush
      n_tests++; if (stall1 !== 1'b1) begin n_fail++; $display("FAIL flush_stall: got %b want 1", stall1); end
      flush = 1'b0;
   endtask

   task automatic test_stall3();
      drain();
      rst3_n = 1'b0; #2; rst3_n = 1'b1;
      set_id(1, 1, 0, 1, 0, 1, 2, 1); tick();   // lw $2,0($1)
      set_id(1, 2, 2, 1, 1, 1, 4, 0); #1;       // add $4,$2,$2
      n_tests++; if (stall3 !== 1'b1) begin n_fail++; $display("FAIL s3_c0: got %b want 1", stall3); end
      tick();
      n_tests++; if (stall3 !== 1'b1) begin n_fail++; $display("FAIL s3_c1: got %b want 1", stall3); end
      tick();
      n_tests++; if (stall3 !== 1'b1) begin n_fail++; $display("FAIL s3_c2: got %b want 1", stall3); end
      tick();
      n_tests++; if (stall3 !== 1'b0) begin n_fail++; $display("FAIL s3_c3: got %b want 0", stall3); end
      tick();
      n_tests++; if ({stall3, fa3, fb3} !== 5'b00000) begin n_fail++; $display("FAIL s3_add: got %b want 00000", {stall3, fa3, fb3}); end
`ifdef FWD_PERF_EN
      n_tests++; if (stall_cnt3 !== 32'd3) begin n_fail++; $display("FAIL s3_stall_cnt: got %0d want 3", stall_cnt3); end
      n_tests++; if (fwd_cnt3 !== 32'd0) begin n_fail++; $display("FAIL s3_fwd_cnt: got %0d want 0", fwd_cnt3); end
      $display("[TB] u_sc1 counters stall=%0d fwd=%0d", stall_cnt1, fwd_cnt1);
`endif
   endtask

   task automatic test_reset_mid_wait();
      drain();
      set_id(1, 1, 0, 1, 0, 1, 2, 1); tick();   // lw $2,0($1)
      set_id(1, 2, 2, 1, 1, 1, 4, 0); tick();   // add held; now second stall cycle
      n_tests++; if (stall3 !== 1'b1) begin n_fail++; $display("FAIL rmw_wait: got %b want 1", stall3); end
      #2; rst3_n = 1'b0; #1;
      n_tests++; if ({stall3, fa3, fb3} !== 5'b00000) begin n_fail++; $display("FAIL rmw_async: got %b want 00000", {stall3, fa3, fb3}); end
      tick();
      n_tests++; if (stall3 !== 1'b0) begin n_fail++; $display("FAIL rmw_held: got %b want 0", stall3); end
      rst3_n = 1'b1; #1;
      n_tests++; if (stall3 !== 1'b0) begin n_fail++; $display("FAIL rmw_release: got %b want 0", stall3); end
      tick();
      n_tests++; if ({stall3, fa3, fb3} !== 5'b00000) begin n_fail++; $display("FAIL rmw_add: got %b want 00000", {stall3, fa3, fb3}); end
   endtask

   initial begin
      test_reset();
      test_mem_forward();
      test_wb_forward();
      test_priority();
      test_zero_reg();
      test_load_use();
      test_back_to_back();
      test_flush();
      test_stall3();
      test_reset_mid_wait();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Producer side of the operand-forwarding interface for the 5-stage MIPS pipeline.
- Tracks destination registers of instructions in the EX, MEM and WB stages.
- Drives the 2-bit forward_a/forward_b select codes consumed by the EX-stage operand muxes: 00 = register file RData, 01 = WB WData, 10 = MEM ALUResult.
- Detects load-use hazards and holds a stall FSM that freezes PC/IF/ID and injects bubbles into EX.

Parameters:
- REG_W, 5, register-number width.
- STALL_CYCLES, 1, stall cycles per load-use hazard (legal 1..3; 2 or 3 for slow data memory).

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- id_valid  input  1  ID holds a real instruction.
- id_rs  input  REG_W  ID source register 1.
- id_rt  input  REG_W  ID source register 2.
- id_use_rs  input  1  ID instruction reads rs.
- id_use_rt  input  1  ID instruction reads rt.
- id_wr_en  input  1  ID instruction writes a register.
- id_wr_reg  input  REG_W  ID destination register.
- id_is_load  input  1  ID instruction is a load (lw/lh/lb...).
- flush  input  1  synchronous: turn the instruction entering EX into a bubble.
- stall  output  1  hold PC and IF/ID; EX receives a bubble.
- forward_a  output  2  select for EX operand A.
- forward_b  output  2  select for EX operand B.

Behaviour:
- Internal stage records, all registered on clk:
  - EX: valid, rs, rt, use_rs, use_rt, wr_en, wr_reg, is_load.
  - MEM: wr_en, wr_reg, is_load.
  - WB: wr_en, wr_reg.
- Every clock, records advance EX->MEM->WB unconditionally. MEM/WB never stall.
- EX load from ID: loads the ID fields when id_valid && !stall && !flush. Otherwise EX loads a bubble (valid=0, wr_en=0, use_*=0).
- Reset (reset_n low, async):
  - All valid and wr_en bits clear; FSM goes to RUN; counter = 0.
  - stall=0, forward_a=forward_b=00 while reset is held and on the first cycle after release.
- Forwarding is combinational from the registered records, no added latency:
  - forward_a = 10 if EX.use_rs && MEM.wr_en && MEM.wr_reg!=0 && MEM.wr_reg==EX.rs.
  - Else 01 if EX.use_rs && WB.wr_en && WB.wr_reg!=0 && WB.wr_reg==EX.rs.
  - Else 00.
  - forward_b uses the same rule on rt.
  - MEM takes priority over WB because it is the younger producer.
  - Register 0 is never forwarded.
  - Code 11 is never driven.
  - A bubble in EX gives 00.
- Load-use hazard:
  - hazard = id_valid && EX.valid && EX.is_load && EX.wr_en && EX.wr_reg!=0 && ((id_use_rs && id_rs==EX.wr_reg) || (id_use_rt && id_rt==EX.wr_reg)).
  - A load in MEM is never forwarded to EX via code 10 (ALUResult is an address). The stall guarantees this case cannot occur.
- FSM states:
  - RUN: stall = hazard. If hazard && STALL_CYCLES>1, go to WAIT with cnt = STALL_CYCLES-1.
  - WAIT: stall=1; cnt decrements each cycle; return to RUN when cnt reaches 1. The last WAIT cycle re-enables ID on the next edge.
- With STALL_CYCLES=1, WAIT is never entered. stall is combinational in RUN, registered in WAIT.
- flush and stall together: flush wins for the EX bubble. The FSM continues counting; PC hold is still asserted.
- Back-to-back load-use (a dependent load followed by its consumer): each hazard is detected and stalled independently.
- reset_n asserted mid-WAIT: immediate return to RUN, stall=0.

Optional Feature:
- Macro: FWD_PERF_EN.
- Defined:
  - Adds output stall_cnt [31:0], which increments on every cycle stall=1.
  - Adds output fwd_cnt [31:0], which increments on every cycle forward_a!=00 or forward_b!=00 (by 1, not 2).
  - Both counters clear on reset and wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- MEM forward: add $3 enters EX, then sub $4,$3,$5 → when sub is in EX, forward_a=10, forward_b=00, stall=0.
- WB forward: add $3; nop; or $6,$7,$3 → or in EX gives forward_b=01.
- Priority: add $3; addi $3; and $8,$3,$3 → and in EX gives forward_a=forward_b=10 (MEM wins over WB).
- $0 writer: ori $0,$1,5 then add $2,$0,$0 → forward_a=forward_b=00.
- Load-use, STALL_CYCLES=1: lw $2,0($1); add $4,$2,$2 → stall=1 for exactly one cycle. EX gets a bubble, then add in EX gives forward_a=forward_b=01.
- Load-use, STALL_CYCLES=3: same sequence → stall high 3 cycles.
  - reset_n pulsed low during the second stall cycle → stall drops to 0 immediately, outputs 00.
  - With FWD_PERF_EN, stall_cnt=3 after a full run without the reset pulse.
